ai_task_dispatcher: RTL and testbench

AI_TASK_DISPATCHER -- requirements
Module: ai_task_dispatcher

---
 rtl/ai_task_dispatcher.sv | 204 ++++++++++++++++++++
 tb/tb_ai_task_dispatcher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ai_task_dispatcher.sv
// rtl/ai_task_dispatcher.sv - round-robin task dispatcher from cores to TPU/VPU units (optional watchdog: AI_DISPATCH_TIMEOUT_EN)
module ai_task_dispatcher #(
  parameter int NUM_CORES      = 4,
  parameter int NUM_TPU        = 2,
  parameter int NUM_VPU        = 2,
  parameter int TASK_ID_W      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CORES-1:0]           core_task_valid,
  input  logic [NUM_CORES*TASK_ID_W-1:0] core_task_id,
  input  logic [NUM_CORES*2-1:0]         core_task_type,
  output logic [NUM_CORES-1:0]           core_task_ready,
  output logic [NUM_CORES-1:0]           core_task_done,
  output logic [NUM_CORES-1:0]           core_task_err,
  output logic [NUM_TPU-1:0]             tpu_start,
  output logic [NUM_VPU-1:0]             vpu_start,
  output logic [NUM_TPU*TASK_ID_W-1:0]   tpu_task_id,
  output logic [NUM_VPU*TASK_ID_W-1:0]   vpu_task_id,
  input  logic [NUM_TPU-1:0]             tpu_done,
  input  logic [NUM_VPU-1:0]             vpu_done,
  output logic [NUM_TPU+NUM_VPU-1:0]     unit_busy,
  output logic                           timeout_flag
);

  localparam int NU = NUM_TPU + NUM_VPU;
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_BUSY = 2'd2} unit_state_t;

  // Units are numbered TPUs first, then VPUs, matching unit_busy.
  unit_state_t            r_state [NU];
  logic [CW-1:0]          r_owner [NU];
  logic [TASK_ID_W-1:0]   r_tid   [NU];
  logic [NU-1:0]          r_start;
  logic [NUM_CORES-1:0]   r_outstanding;
  logic [NUM_CORES-1:0]   r_done;
  logic [NUM_CORES-1:0]   r_err;
  logic [CW-1:0]          r_rr_ptr;

  logic [NU-1:0]          w_unit_done;
  logic [NU-1:0]          w_timeout;
  logic [NU-1:0]          w_idle;
  logic [NU-1:0]          w_alloc;
  logic [NUM_CORES-1:0]   w_elig;
  logic [NUM_CORES-1:0]   w_grant;
  logic [NUM_CORES-1:0]   w_set;
  logic [NUM_CORES-1:0]   w_done_nxt;
  logic [NUM_CORES-1:0]   w_err_nxt;
  logic                   w_found;
  logic                   w_hit;
  logic [CW-1:0]          w_gidx;
  logic [1:0]             w_gtype;
  logic [TASK_ID_W-1:0]   w_gtid;
  int                     w_c;

  assign w_unit_done = {vpu_done, tpu_done};

  // Eligibility, round-robin grant and lowest-index unit selection.
  always_comb begin
    w_idle  = '0;
    w_elig  = '0;
    w_grant = '0;
    w_alloc = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_gidx  = '0;
    w_c     = 0;
    for (int u = 0; u < NU; u++) w_idle[u] = (r_state[u] == S_IDLE);
    for (int c = 0; c < NUM_CORES; c++) begin
      w_elig[c] = core_task_valid[c] && !r_outstanding[c] &&
                  (core_task_type[c*2+1] ||
                   (!core_task_type[c*2] && (|w_idle[NUM_TPU-1:0])) ||
                   ( core_task_type[c*2] && (|w_idle[NU-1:NUM_TPU])));
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      w_c = (int'(r_rr_ptr) + i) % NUM_CORES;
      if (!w_found && w_elig[w_c]) begin
        w_found = 1'b1;
        w_gidx  = CW'(w_c);
      end
    end
    w_found = w_found && rst_n;
    if (w_found) w_grant[w_gidx] = 1'b1;
    w_gtype = core_task_type[int'(w_gidx)*2 +: 2];
    w_gtid  = core_task_id[int'(w_gidx)*TASK_ID_W +: TASK_ID_W];
    if (w_found && !w_gtype[1]) begin
      if (!w_gtype[0]) begin
        for (int u = 0; u < NUM_TPU; u++)
          if (!w_hit && w_idle[u]) begin w_alloc[u] = 1'b1; w_hit = 1'b1; end
      end else begin
        for (int u = NUM_TPU; u < NU; u++)
          if (!w_hit && w_idle[u]) begin w_alloc[u] = 1'b1; w_hit = 1'b1; end
      end
    end
    w_set = (|w_alloc) ? w_grant : '0;
  end

  // Per-core completion/error events for the next cycle; done beats timeout.
  always_comb begin
    w_done_nxt = '0;
    w_err_nxt  = '0;
    for (int u = 0; u < NU; u++) begin
      if (!w_idle[u]) begin
        if (w_unit_done[u])    w_done_nxt[r_owner[u]] = 1'b1;
        else if (w_timeout[u]) w_err_nxt[r_owner[u]]  = 1'b1;
      end
    end
    if (w_found && w_gtype[1]) w_err_nxt[w_gidx] = 1'b1;
  end

  // Unit FSMs: IDLE -> START on allocation, START -> BUSY, any active -> IDLE on done/timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= '0;
      for (int u = 0; u < NU; u++) begin
        r_state[u] <= S_IDLE;
        r_owner[u] <= '0;
        r_tid[u]   <= '0;
      end
    end else begin
      r_start <= w_alloc;
      for (int u = 0; u < NU; u++) begin
        case (r_state[u])
          S_IDLE: begin
            if (w_alloc[u]) begin
              r_state[u] <= S_START;
              r_owner[u] <= w_gidx;
              r_tid[u]   <= w_gtid;
            end
          end
          S_START, S_BUSY: begin
            if (w_unit_done[u] || w_timeout[u]) r_state[u] <= S_IDLE;
            else                                r_state[u] <= S_BUSY;
          end
          default: r_state[u] <= S_IDLE;
        endcase
      end
    end
  end

  // Core-side bookkeeping: round-robin pointer, outstanding bits, done/err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
      r_done        <= '0;
      r_err         <= '0;
    end else begin
      if (w_found) r_rr_ptr <= (int'(w_gidx) == NUM_CORES-1) ? '0 : w_gidx + 1'b1;
      r_outstanding <= (r_outstanding | w_set) & ~(w_done_nxt | w_err_nxt);
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
    end
  end

`ifdef AI_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_cnt [NU];
  logic          r_timeout_flag;

  // Expiry is flagged on the TIMEOUT_CYCLES-th active cycle of a unit.
  always_comb begin
    w_timeout = '0;
    for (int u = 0; u < NU; u++)
      w_timeout[u] = !w_idle[u] && (r_cnt[u] == TW'(TIMEOUT_CYCLES - 1));
  end

  // Per-unit active-cycle counters and the sticky watchdog flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_flag <= 1'b0;
      for (int u = 0; u < NU; u++) r_cnt[u] <= '0;
    end else begin
      if (|(w_timeout & ~w_unit_done)) r_timeout_flag <= 1'b1;
      for (int u = 0; u < NU; u++) begin
        if (w_idle[u] || w_unit_done[u] || w_timeout[u]) r_cnt[u] <= '0;
        else                                              r_cnt[u] <= r_cnt[u] + 1'b1;
      end
    end
  end

  assign timeout_flag = r_timeout_flag;
`else
  assign w_timeout    = '0;
  assign timeout_flag = 1'b0;
`endif

  // Output mapping; ready is forced low while reset is held.
  always_comb begin
    core_task_ready = w_grant;
    core_task_done  = r_done;
    core_task_err   = r_err;
    tpu_start       = r_start[NUM_TPU-1:0];
    vpu_start       = r_start[NU-1:NUM_TPU];
    unit_busy       = ~w_idle;
    tpu_task_id     = '0;
    vpu_task_id     = '0;
    for (int u = 0; u < NUM_TPU; u++) tpu_task_id[u*TASK_ID_W +: TASK_ID_W] = r_tid[u];
    for (int u = 0; u < NUM_VPU; u++) vpu_task_id[u*TASK_ID_W +: TASK_ID_W] = r_tid[NUM_TPU+u];
  end

endmodule

// File: tb/tb_ai_task_dispatcher.sv
// tb/tb_ai_task_dispatcher.sv - directed self-checking bench for ai_task_dispatcher
module tb_ai_task_dispatcher;

  logic        clk;
  logic        rst_n;
  logic [3:0]  core_task_valid;
  logic [31:0] core_task_id;
  logic [7:0]  core_task_type;
  logic [3:0]  core_task_ready;
  logic [3:0]  core_task_done;
  logic [3:0]  core_task_err;
  logic [1:0]  tpu_start;
  logic [1:0]  vpu_start;
  logic [15:0] tpu_task_id;
  logic [15:0] vpu_task_id;
  logic [1:0]  tpu_done;
  logic [1:0]  vpu_done;
  logic [3:0]  unit_busy;
  logic        timeout_flag;

  int vectors = 0;
  int miscompares = 0;

  ai_task_dispatcher dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_task_valid (core_task_valid),
    .core_task_id    (core_task_id),
    .core_task_type  (core_task_type),
    .core_task_ready (core_task_ready),
    .core_task_done  (core_task_done),
    .core_task_err   (core_task_err),
    .tpu_start       (tpu_start),
    .vpu_start       (vpu_start),
    .tpu_task_id     (tpu_task_id),
    .vpu_task_id     (vpu_task_id),
    .tpu_done        (tpu_done),
    .vpu_done        (vpu_done),
    .unit_busy       (unit_busy),
    .timeout_flag    (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_core(input int c, input logic v, input logic [7:0] tid, input logic [1:0] t);
    core_task_valid[c]    = v;
    core_task_id[c*8 +: 8] = tid;
    core_task_type[c*2 +: 2] = t;
  endtask

  task automatic do_reset;
    core_task_valid = '0;
    core_task_id    = '0;
    core_task_type  = '0;
    tpu_done        = '0;
    vpu_done        = '0;
    rst_n           = 1'b0;
    #1;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    core_task_valid = '0;
    core_task_id    = '0;
    core_task_type  = '0;
    tpu_done        = '0;
    vpu_done        = '0;
    set_core(0, 1'b1, 8'h77, 2'b00);
    #12;
    chk("rst_ready",   core_task_ready, 4'b0000);
    chk("rst_busy",    unit_busy,       4'b0000);
    chk("rst_done",    core_task_done,  4'b0000);
    chk("rst_err",     core_task_err,   4'b0000);
    chk("rst_start",   {tpu_start, vpu_start}, 4'b0000);
    chk("rst_ids",     {tpu_task_id, vpu_task_id}, 32'h0);
    chk("rst_timeout", timeout_flag,    1'b0);
    rst_n = 1'b1;
    set_core(0, 1'b0, 8'h00, 2'b00);
    tick;

    // single TPU task on core0
    set_core(0, 1'b1, 8'h11, 2'b00);
    #1 chk("t1_ready", core_task_ready, 4'b0001);
    tick;
    set_core(0, 1'b0, 8'h11, 2'b00);
    #1 chk("t1_start", tpu_start, 2'b01);
    chk("t1_id",   tpu_task_id[7:0], 8'h11);
    chk("t1_busy", unit_busy, 4'b0001);
    chk("t1_nodone", core_task_done, 4'b0000);
    tick;
    chk("t1_start_off", tpu_start, 2'b00);
    chk("t1_busy2", unit_busy, 4'b0001);
    tpu_done = 2'b01;
    tick;
    tpu_done = 2'b00;
    #1 chk("t1_done", core_task_done, 4'b0001);
    chk("t1_idle", unit_busy, 4'b0000);
    tick;
    chk("t1_done_off", core_task_done, 4'b0000);

    // four cores contend for two TPUs
    do_reset;
    set_core(0, 1'b1, 8'hA0, 2'b00);
    set_core(1, 1'b1, 8'hA1, 2'b00);
    set_core(2, 1'b1, 8'hA2, 2'b00);
    set_core(3, 1'b1, 8'hA3, 2'b00);
    #1 chk("rr_g0", core_task_ready, 4'b0001);
    tick;
    set_core(0, 1'b0, 8'hA0, 2'b00);
    #1 chk("rr_g1", core_task_ready, 4'b0010);
    tick;
    set_core(1, 1'b0, 8'hA1, 2'b00);
    #1 chk("rr_full", core_task_ready, 4'b0000);
    chk("rr_ids",   tpu_task_id, 16'hA1A0);
    chk("rr_busy",  unit_busy, 4'b0011);
    chk("rr_start", tpu_start, 2'b10);
    tick;
    chk("rr_stall", core_task_ready, 4'b0000);
    tpu_done = 2'b01;
    #1 chk("rr_noreuse", core_task_ready, 4'b0000);
    tick;
    tpu_done = 2'b00;
    #1 chk("rr_done0", core_task_done, 4'b0001);
    chk("rr_g2", core_task_ready, 4'b0100);
    tick;
    set_core(2, 1'b0, 8'hA2, 2'b00);
    #1 chk("rr_start2", tpu_start, 2'b01);
    chk("rr_ids2", tpu_task_id, 16'hA1A2);
    chk("rr_core3_wait", core_task_ready, 4'b0000);

    // VPU request passes a stalled TPU request
    do_reset;
    set_core(0, 1'b1, 8'h20, 2'b00);
    #1 chk("mx_g0", core_task_ready, 4'b0001);
    tick;
    set_core(0, 1'b0, 8'h20, 2'b00);
    set_core(3, 1'b1, 8'h23, 2'b00);
    #1 chk("mx_g3", core_task_ready, 4'b1000);
    tick;
    set_core(3, 1'b0, 8'h23, 2'b00);
    set_core(1, 1'b1, 8'h31, 2'b01);
    set_core(2, 1'b1, 8'h32, 2'b00);
    #1 chk("mx_vpu_g1", core_task_ready, 4'b0010);
    tick;
    set_core(1, 1'b0, 8'h31, 2'b01);
    #1 chk("mx_tpu_wait", core_task_ready, 4'b0000);
    chk("mx_vstart", vpu_start, 2'b01);
    chk("mx_vid",    vpu_task_id, 16'h0031);
    chk("mx_busy",   unit_busy, 4'b0111);

    // core3 finishes and immediately issues an illegal-type task
    tpu_done = 2'b10;
    tick;
    tpu_done = 2'b00;
    set_core(2, 1'b0, 8'h32, 2'b00);
    set_core(3, 1'b1, 8'h33, 2'b10);
    #1 chk("il_done3",  core_task_done, 4'b1000);
    chk("il_ready3", core_task_ready, 4'b1000);
    tick;
    set_core(3, 1'b0, 8'h33, 2'b10);
    #1 chk("il_err3",  core_task_err, 4'b1000);
    chk("il_busy",  unit_busy, 4'b0101);
    chk("il_nostart", {tpu_start, vpu_start}, 4'b0000);
    chk("il_nodone", core_task_done, 4'b0000);
    tick;
    chk("il_err_off", core_task_err, 4'b0000);

    // done on an idle unit is ignored
    tpu_done = 2'b10;
    tick;
    tpu_done = 2'b00;
    #1 chk("sp_done", core_task_done, 4'b0000);
    chk("sp_err",  core_task_err, 4'b0000);
    chk("sp_busy", unit_busy, 4'b0101);
`ifndef AI_DISPATCH_TIMEOUT_EN
    chk("sp_timeout", timeout_flag, 1'b0);
`endif

    // asynchronous reset with TPU0 and VPU0 busy
    set_core(2, 1'b1, 8'h44, 2'b00);
    #1 chk("ar_pre_ready", core_task_ready, 4'b0100);
    rst_n = 1'b0;
    #1 chk("ar_ready", core_task_ready, 4'b0000);
    chk("ar_busy", unit_busy, 4'b0000);
    chk("ar_ids",  {tpu_task_id, vpu_task_id}, 32'h0);
    tick;
    rst_n = 1'b1;
    set_core(2, 1'b0, 8'h44, 2'b00);
    tpu_done = 2'b01;
    vpu_done = 2'b01;
    tick;
    tpu_done = 2'b00;
    vpu_done = 2'b00;
    #1 chk("ar_nodone", core_task_done, 4'b0000);
    chk("ar_noerr", core_task_err, 4'b0000);
    chk("ar_idle",  unit_busy, 4'b0000);

`ifdef AI_DISPATCH_TIMEOUT_EN
    // watchdog expiry on a TPU held without done
    do_reset;
    set_core(0, 1'b1, 8'h55, 2'b00);
    tick;
    set_core(0, 1'b0, 8'h55, 2'b00);
    repeat (1023) tick;
    chk("to_before_busy", unit_busy, 4'b0001);
    chk("to_before_err",  core_task_err, 4'b0000);
    tick;
    chk("to_err",  core_task_err, 4'b0001);
    chk("to_flag", timeout_flag, 1'b1);
    chk("to_idle", unit_busy, 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
